// File: rtl/psum_pkg.sv
// rtl/psum_pkg.sv - packet constants, field positions and saturating add for the partial-sum adder
package psum_pkg;

   localparam int PACKET_W = 40;
   localparam int HDR_W    = 8;
   localparam int DATA_W   = 13;

   localparam int HDR_LSB  = PACKET_W - HDR_W;
   localparam int DATA_LSB = 0;
   localparam int PAD_W    = HDR_LSB - DATA_W;

   typedef logic [PACKET_W-1:0] packet_t;
   typedef logic [DATA_W-1:0]   data_t;
   typedef logic [HDR_W-1:0]    hdr_t;

   // Unsigned add clamped to the all-ones data value on carry-out.
   function automatic data_t sat_add(input data_t a, input data_t b);
      logic [DATA_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[DATA_W] ? {DATA_W{1'b1}} : s[DATA_W-1:0];
   endfunction

endpackage

// File: rtl/psum_in_slot.sv
// rtl/psum_in_slot.sv - one-entry valid/ready holding register released by an external consume
module psum_in_slot #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         valid,
   output logic         ready,
   input  logic [W-1:0] data,
   input  logic         consume,
   output logic         full,
   output logic [W-1:0] q
);

   // Consume frees the entry on the same edge, so a refill never costs a bubble.
   assign ready = !full || consume;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full <= 1'b0;
         q    <= '0;
      end else if (valid && ready) begin
         full <= 1'b1;
         q    <= data;
      end else if (consume) begin
         full <= 1'b0;
      end
   end

endmodule

// File: rtl/psum_adder.sv
// rtl/psum_adder.sv - joins one packet from each input and emits the saturated sum of their data fields
module psum_adder
   import psum_pkg::*;
(
   input  logic    clk,
   input  logic    rst_n,
   input  logic    in1_valid,
   output logic    in1_ready,
   input  packet_t in1_data,
   input  logic    in2_valid,
   output logic    in2_ready,
   input  packet_t in2_data,
   output logic    out_valid,
   input  logic    out_ready,
   output packet_t out_data
);

   localparam int SLOT1_W = HDR_W + DATA_W;

   logic               full1;
   logic               full2;
   logic               do_join;
   logic [SLOT1_W-1:0] q1;
   data_t              q2;
   packet_t            result;
   logic               unused_bits;

   // Only the fields that reach the result are held; the rest of each packet is dropped here.
   assign unused_bits = ^{in1_data[HDR_LSB-1:DATA_W], in2_data[PACKET_W-1:DATA_W]};

   assign do_join = full1 && full2 && (!out_valid || out_ready);

   psum_in_slot #(.W(SLOT1_W)) u_in1 (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid   (in1_valid),
      .ready   (in1_ready),
      .data    ({in1_data[HDR_LSB +: HDR_W], in1_data[DATA_LSB +: DATA_W]}),
      .consume (do_join),
      .full    (full1),
      .q       (q1)
   );

   psum_in_slot #(.W(DATA_W)) u_in2 (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid   (in2_valid),
      .ready   (in2_ready),
      .data    (in2_data[DATA_LSB +: DATA_W]),
      .consume (do_join),
      .full    (full2),
      .q       (q2)
   );

   assign result = {q1[SLOT1_W-1 -: HDR_W], {PAD_W{1'b0}}, sat_add(q1[DATA_W-1:0], q2)};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (do_join) begin
         out_valid <= 1'b1;
         out_data  <= result;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_psum_adder.sv
// tb/tb_psum_adder.sv - self-checking bench for psum_adder
module tb_psum_adder;
   import psum_pkg::*;

   logic    clk = 1'b0;
   logic    rst_n;
   logic    in1_valid, in1_ready, in2_valid, in2_ready, out_valid, out_ready;
   packet_t in1_data, in2_data, out_data;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   psum_adder dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in1_valid (in1_valid),
      .in1_ready (in1_ready),
      .in1_data  (in1_data),
      .in2_valid (in2_valid),
      .in2_ready (in2_ready),
      .in2_data  (in2_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   typedef struct {
      packet_t a;
      packet_t b;
      packet_t e;
   } vec_t;

   packet_t s1[64];
   packet_t s2[64];
   packet_t ex[64];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: header of in1, zero pad, data fields added and clamped to 8191.
   function automatic packet_t ref_out(input packet_t a, input packet_t b);
      int      s;
      packet_t r;
      s = int'(a[12:0]) + int'(b[12:0]);
      if (s > 8191) s = 8191;
      r = '0;
      r[39:32] = a[39:32];
      r[12:0]  = s[12:0];
      return r;
   endfunction

   // Streams s1/s2 pairs with random valid/ready gaps, checks each result in order against ex.
   task automatic run_stream(input int n, input int vpct, input int rpct, input int hold,
                             output int first_c, output int last_c);
      int      i1 = 0;
      int      i2 = 0;
      int      o = 0;
      int      cyc = 0;
      logic    v1 = 1'b0;
      logic    v2 = 1'b0;
      logic    prev_stall = 1'b0;
      packet_t prev = '0;
      first_c = -1;
      last_c  = -1;
      while (o < n && cyc < 3000) begin
         @(negedge clk);
         if (!v1 && i1 < n) v1 = ($urandom_range(99) < vpct);
         if (!v2 && i2 < n) v2 = ($urandom_range(99) < vpct);
         in1_valid = v1;
         in2_valid = v2;
         in1_data  = (i1 < n) ? s1[i1] : '0;
         in2_data  = (i2 < n) ? s2[i2] : '0;
         out_ready = (cyc >= hold) && ($urandom_range(99) < rpct);
         #1;
         if (prev_stall) check("hold_stable", out_data, prev);
         if (hold >= 5 && cyc == 4) begin
            check("bp_in1_ready", in1_ready, 0);
            check("bp_in2_ready", in2_ready, 0);
         end
         if (in1_valid && in1_ready) begin i1++; v1 = 1'b0; end
         if (in2_valid && in2_ready) begin i2++; v2 = 1'b0; end
         if (out_valid && out_ready) begin
            if (o < n) check($sformatf("result_%0d", o), out_data, ex[o]);
            if (first_c < 0) first_c = cyc;
            last_c = cyc;
            o++;
         end
         prev_stall = out_valid && !out_ready;
         prev = out_data;
         cyc++;
      end
      if (o < n) begin
         checks++;
         errors++;
         $display("FAIL stream_timeout: got %0d results expected %0d", o, n);
      end
      @(negedge clk);
      in1_valid = 1'b0;
      in2_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      #1 check("no_extra_output", out_valid, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[6];
      int   fc, lc;

      tbl[0] = '{40'hA5_0000_0003, 40'h11_0000_0004, 40'hA5_0000_0007};
      tbl[1] = '{40'h00_FFFF_FFFE, 40'h00_0000_0005, 40'h00_0000_1FFF};
      tbl[2] = '{40'hFF_0000_1FFF, 40'h33_FFFF_FFFF, 40'hFF_0000_1FFF};
      tbl[3] = '{40'h7E_0000_0000, 40'h01_0000_0000, 40'h7E_0000_0000};
      tbl[4] = '{40'h12_0000_1000, 40'h00_0000_0FFF, 40'h12_0000_1FFF};
      tbl[5] = '{40'hC3_1234_5000, 40'h00_0000_1000, 40'hC3_0000_1FFF};

      rst_n = 1'b0;
      in1_valid = 1'b0; in2_valid = 1'b0; out_ready = 1'b0;
      in1_data = '0; in2_data = '0;
      repeat (3) @(negedge clk);
      #1;
      check("reset_out_valid", out_valid, 0);
      check("reset_out_data", out_data, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("reset_in1_ready", in1_ready, 1);
      check("reset_in2_ready", in2_ready, 1);

      for (int i = 0; i < 6; i++) begin
         s1[i] = tbl[i].a;
         s2[i] = tbl[i].b;
         ex[i] = tbl[i].e;
      end
      run_stream(6, 100, 100, 0, fc, lc);
      run_stream(6, 60, 70, 0, fc, lc);

      // Second in1 packet must wait until the first pair joins.
      @(negedge clk);
      in1_valid = 1'b1; in1_data = 40'h1; out_ready = 1'b1;
      #1 check("stall_first_ready", in1_ready, 1);
      @(negedge clk);
      in1_data = 40'h2;
      #1 check("stall_in1_ready", in1_ready, 0);
      check("stall_in2_ready", in2_ready, 1);
      @(negedge clk);
      in2_valid = 1'b1; in2_data = 40'd10;
      #1 check("stall_in1_held", in1_ready, 0);
      @(negedge clk);
      in2_data = 40'd20;
      #1 check("pair_in1_ready", in1_ready, 1);
      @(negedge clk);
      in1_valid = 1'b0; in2_valid = 1'b0;
      #1 check("order_first_valid", out_valid, 1);
      check("order_first", out_data, 40'd11);
      @(negedge clk);
      #1 check("order_second", out_data, 40'd22);
      @(negedge clk);
      #1 check("order_drained", out_valid, 0);

      for (int i = 0; i < 10; i++) begin
         s1[i] = {8'(i + 1), 19'($urandom), 13'($urandom)};
         s2[i] = {8'($urandom), 19'($urandom), 13'($urandom)};
         ex[i] = ref_out(s1[i], s2[i]);
      end
      run_stream(10, 100, 100, 5, fc, lc);

      run_stream(10, 100, 100, 0, fc, lc);
      check("stream_latency", fc, 2);
      check("stream_rate", lc - fc, 9);

      for (int i = 0; i < 40; i++) begin
         s1[i] = {$urandom, $urandom} & 40'hFF_FFFF_FFFF;
         s2[i] = {$urandom, $urandom} & 40'hFF_FFFF_FFFF;
         if (i % 3 == 0) s1[i][12] = 1'b1;
         if (i % 3 == 0) s2[i][12] = 1'b1;
         ex[i] = ref_out(s1[i], s2[i]);
      end
      run_stream(40, 50, 50, 0, fc, lc);

      // Reset with both slots full and a stalled output pending.
      @(negedge clk);
      in1_valid = 1'b1; in1_data = 40'h05_0000_0100;
      in2_valid = 1'b1; in2_data = 40'h00_0000_0200;
      out_ready = 1'b0;
      @(negedge clk);
      in1_data = 40'h06_0000_0300;
      in2_data = 40'h00_0000_0400;
      @(negedge clk);
      in1_valid = 1'b0; in2_valid = 1'b0;
      #1 check("pre_reset_valid", out_valid, 1);
      #1 rst_n = 1'b0;
      #1 check("async_reset_valid", out_valid, 0);
      check("async_reset_data", out_data, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 check("post_reset_in1_ready", in1_ready, 1);
      check("post_reset_in2_ready", in2_ready, 1);
      s1[0] = 40'h9A_0000_0011;
      s2[0] = 40'h00_0000_0022;
      ex[0] = ref_out(s1[0], s2[0]);
      run_stream(1, 100, 100, 0, fc, lc);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
